// File: rtl/pokey_audio_gen.sv
// POKEY-compatible audio generator: CHANNELS tone/noise channels with optional
// 16-bit pair linking, shared poly4/poly9/poly17 noise sources and a registered mixer.
//
// Ports:
//   phi2     - system clock, all state on the rising edge
//   reset    - synchronous, active-high
//   tick     - one-phi2 base audio clock strobe (dividers advance only on it)
//   we, cs   - write strobe and chip select; a write happens when both are high
//   a, d_in  - register address and write data
//   aud      - registered, unsigned mixed output
//   chan_out - raw per-channel output bits
module pokey_audio_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned OUT_W    = 6
) (
    input  logic                phi2,
    input  logic                reset,
    input  logic                tick,
    input  logic                we,
    input  logic                cs,
    input  logic [4:0]          a,
    input  logic [7:0]          d_in,
    output logic [OUT_W-1:0]    aud,
    output logic [CHANNELS-1:0] chan_out
);

    localparam int unsigned PAIRS = CHANNELS / 2;

    // audc_q packs the used AUDC fields: [6] tone, [5] poly4 select, [4] volume-only, [3:0] volume
    logic [7:0]          audf_q [CHANNELS];
    logic [6:0]          audc_q [CHANNELS];
    logic [PAIRS-1:0]    link_q;
    logic                poly9_q;

    logic [7:0]          cnt_q [CHANNELS];
    logic [7:0]          cnt_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] uf;
    logic [CHANNELS-1:0] muted;
    logic [3:0]          poly4_q;
    logic [16:0]         poly17_q;
    logic [OUT_W-1:0]    aud_q, mix;

    logic wr, restart;

    assign wr      = we & cs;
    assign restart = wr && (a == 5'h1F);

    // The low channel of a linked pair carries no output of its own.
    always_comb begin
        muted = '0;
        for (int unsigned p = 0; p < PAIRS; p++) begin
            muted[2*p] = link_q[p];
        end
    end

    // Register file; writes become visible to the dividers/mixer on the next cycle.
    always_ff @(posedge phi2) begin
        if (reset) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                audf_q[n] <= '0;
                audc_q[n] <= '0;
            end
            link_q  <= '0;
            poly9_q <= 1'b0;
        end else if (wr) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (a == 5'(2*n))     audf_q[n] <= d_in;
                if (a == 5'(2*n + 1)) audc_q[n] <= {d_in[7], d_in[5:0]};
            end
            if (a == 5'h1E) begin
                link_q  <= d_in[PAIRS-1:0];
                poly9_q <= d_in[7];
            end
        end
    end

    // Dividers. Reload and underflow always use the pre-write AUDF (audf_q).
    always_comb begin
        logic [15:0] pair_cnt;
        logic [15:0] pair_rld;
        logic [15:0] pair_nxt;
        pair_cnt = '0;
        pair_rld = '0;
        pair_nxt = '0;
        uf       = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            cnt_d[n] = cnt_q[n];
            if (!link_q[n/2]) begin
                if (restart) begin
                    cnt_d[n] = audf_q[n];
                end else if (tick) begin
                    if (cnt_q[n] == 8'd0) begin
                        cnt_d[n] = audf_q[n];
                        uf[n]    = 1'b1;
                    end else begin
                        cnt_d[n] = cnt_q[n] - 8'd1;
                    end
                end
            end
        end
        for (int unsigned p = 0; p < PAIRS; p++) begin
            if (link_q[p]) begin
                pair_cnt = {cnt_q[2*p+1], cnt_q[2*p]};
                pair_rld = {audf_q[2*p+1], audf_q[2*p]};
                pair_nxt = pair_cnt;
                if (restart) begin
                    pair_nxt = pair_rld;
                end else if (tick) begin
                    if (pair_cnt == 16'd0) begin
                        pair_nxt     = pair_rld;
                        uf[2*p+1]    = 1'b1;
                    end else begin
                        pair_nxt = pair_cnt - 16'd1;
                    end
                end
                cnt_d[2*p+1] = pair_nxt[15:8];
                cnt_d[2*p]   = pair_nxt[7:0];
            end
        end
    end

    // Channel output bits change only on underflow; restart clears them.
    always_comb begin
        out_d = out_q;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (restart || muted[n]) begin
                out_d[n] = 1'b0;
            end else if (uf[n]) begin
                if (audc_q[n][6]) begin
                    out_d[n] = ~out_q[n];
                end else if (audc_q[n][5]) begin
                    out_d[n] = poly4_q[3];
                end else begin
                    out_d[n] = poly9_q ? poly17_q[8] : poly17_q[16];
                end
            end
        end
    end

    // Mixer; OUT_W is sized so the sum cannot overflow.
    always_comb begin
        mix = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (!muted[n] && (audc_q[n][4] || out_q[n])) begin
                mix = mix + OUT_W'(audc_q[n][3:0]);
            end
        end
    end

    always_ff @(posedge phi2) begin
        if (reset) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= '0;
            end
            out_q    <= '0;
            poly4_q  <= '1;
            poly17_q <= '1;
            aud_q    <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            out_q    <= out_d;
            poly4_q  <= {poly4_q[2:0], poly4_q[3] ^ poly4_q[2]};
            // 9-bit mode reuses the low bits of the same register, so no reseed on switch.
            poly17_q <= {poly17_q[15:0], poly9_q ? (poly17_q[8] ^ poly17_q[4])
                                                 : (poly17_q[16] ^ poly17_q[13])};
            aud_q    <= mix;
        end
    end

    assign aud      = aud_q;
    assign chan_out = out_q;

endmodule

// File: tb/tb_pokey_audio_gen.sv
// Directed bench for pokey_audio_gen (CHANNELS=4, OUT_W=6). Inputs are driven and
// outputs sampled on the falling edge of phi2.
module tb_pokey_audio_gen;

    logic       phi2;
    logic       reset;
    logic       tick;
    logic       we;
    logic       cs;
    logic [4:0] a;
    logic [7:0] d_in;
    logic [5:0] aud;
    logic [3:0] chan_out;

    int n_checks;
    int n_pass;

    pokey_audio_gen #(
        .CHANNELS (4),
        .OUT_W    (6)
    ) dut (
        .phi2     (phi2),
        .reset    (reset),
        .tick     (tick),
        .we       (we),
        .cs       (cs),
        .a        (a),
        .d_in     (d_in),
        .aud      (aud),
        .chan_out (chan_out)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write is sampled on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic wr_reg(input logic [4:0] addr, input logic [7:0] data);
        cs   = 1'b1;
        we   = 1'b1;
        a    = addr;
        d_in = data;
        @(negedge phi2);
        cs   = 1'b0;
        we   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge phi2);
        reset = 1'b0;
    endtask

    logic [14:0] noise_seq;
    logic        saw_nonzero;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        tick     = 1'b0;
        we       = 1'b0;
        cs       = 1'b0;
        a        = '0;
        d_in     = '0;
        @(negedge phi2);
        @(negedge phi2);
        reset = 1'b0;

        // Reset in the middle of a note.
        wr_reg(5'h00, 8'h01);
        wr_reg(5'h01, 8'hAF);
        wr_reg(5'h1E, 8'h80);
        tick = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge phi2);
        reset = 1'b1;
        @(negedge phi2);
        check_eq("reset_aud", 32'(aud), 32'd0);
        check_eq("reset_chan", 32'(chan_out), 32'd0);
        reset = 1'b0;
        saw_nonzero = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge phi2);
            if (aud != 6'd0) saw_nonzero = 1'b1;
        end
        check_eq("reset_silent", 32'(saw_nonzero), 32'd0);

        // Tone: AUDF0=3 -> toggle every 4 ticks, aud one cycle behind.
        tick = 1'b0;
        do_reset();
        wr_reg(5'h00, 8'h03);
        wr_reg(5'h01, 8'hAF);
        wr_reg(5'h1F, 8'h00);
        check_eq("tone_start", 32'(chan_out), 32'd0);
        tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge phi2);
            check_eq("tone_chan", 32'(chan_out[0]), 32'((k / 4) % 2));
            check_eq("tone_aud", 32'(aud), 32'(15 * (((k - 1) / 4) % 2)));
        end

        // Volume-only mix and its two-cycle latency.
        tick = 1'b0;
        do_reset();
        wr_reg(5'h01, 8'h1F);
        wr_reg(5'h03, 8'h1F);
        wr_reg(5'h05, 8'h1F);
        wr_reg(5'h07, 8'h1F);
        @(negedge phi2);
        check_eq("volonly_60", 32'(aud), 32'd60);
        wr_reg(5'h05, 8'h10);
        check_eq("volonly_lat", 32'(aud), 32'd60);
        @(negedge phi2);
        check_eq("volonly_45", 32'(aud), 32'd45);

        // Noise from poly4 with AUDF0=0: every tick samples the poly4 MSB.
        // MSB of poly4 states after reset: 1,1,1,1,0,0,0,1,0,0,1,1,0,1,0 (bit i = state i).
        noise_seq = 15'b010110010001111;
        tick = 1'b1;
        do_reset();
        wr_reg(5'h01, 8'h2F);
        for (int i = 0; i < 20; i++) begin
            @(negedge phi2);
            check_eq("noise_poly4", 32'(chan_out[0]), 32'(noise_seq[(i + 1) % 15]));
        end

        // Linked pair 0/1, reload 16'h0101 -> period 258 ticks.
        tick = 1'b0;
        do_reset();
        wr_reg(5'h1E, 8'h01);
        wr_reg(5'h00, 8'h01);
        wr_reg(5'h02, 8'h01);
        wr_reg(5'h03, 8'hA8);
        wr_reg(5'h1F, 8'h00);
        tick = 1'b1;
        for (int k = 1; k <= 520; k++) begin
            @(negedge phi2);
            if (k == 257) check_eq("link_pre", 32'(chan_out[1]), 32'd0);
            if (k == 258) begin
                check_eq("link_toggle", 32'(chan_out[1]), 32'd1);
                check_eq("link_low_zero", 32'(chan_out[0]), 32'd0);
                check_eq("link_aud_lag", 32'(aud), 32'd0);
            end
            if (k == 259) check_eq("link_aud", 32'(aud), 32'd8);
            if (k == 515) check_eq("link_hold", 32'(chan_out[1]), 32'd1);
            if (k == 516) check_eq("link_toggle2", 32'(chan_out[1]), 32'd0);
        end

        // RESTART on the underflow tick, then an AUDF write on an underflow tick.
        tick = 1'b0;
        do_reset();
        wr_reg(5'h00, 8'h02);
        wr_reg(5'h01, 8'hAF);
        tick = 1'b1;
        wr_reg(5'h1F, 8'h00);                   // cnt0 = 2
        @(negedge phi2);                        // cnt0 = 1
        @(negedge phi2);                        // cnt0 = 0
        check_eq("coll_pre", 32'(chan_out[0]), 32'd0);
        wr_reg(5'h1F, 8'h00);                   // restart beats underflow, cnt0 = 2
        check_eq("coll_restart", 32'(chan_out[0]), 32'd0);
        @(negedge phi2);
        @(negedge phi2);
        check_eq("coll_cnt_hold", 32'(chan_out[0]), 32'd0);
        @(negedge phi2);
        check_eq("coll_reload", 32'(chan_out[0]), 32'd1);
        @(negedge phi2);
        @(negedge phi2);                        // cnt0 = 0
        wr_reg(5'h00, 8'h05);                   // underflow reloads old AUDF0 = 2
        check_eq("audf_uf_toggle", 32'(chan_out[0]), 32'd0);
        @(negedge phi2);
        @(negedge phi2);
        check_eq("audf_old_pre", 32'(chan_out[0]), 32'd0);
        @(negedge phi2);
        check_eq("audf_old_reload", 32'(chan_out[0]), 32'd1);
        for (int i = 0; i < 5; i++) @(negedge phi2);
        check_eq("audf_new_pre", 32'(chan_out[0]), 32'd1);
        @(negedge phi2);
        check_eq("audf_new_reload", 32'(chan_out[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pokey_audio_gen.md
# pokey_audio_gen

Parametrised POKEY-compatible audio generator: N programmable tone/noise channels, optional 16-bit pair linking, shared polynomial noise sources and a registered mixer. It replaces the fixed four-channel chip wrapper in the sound path of the arcade cores. The CPU write bus connects directly, and the mixed `aud` output feeds the DAC/filter stage. Keyboard, serial, IRQ and pot logic are out of scope.

## Interface
- `CHANNELS`, default 4: number of channels, 2..8, even.
- `OUT_W`, default 6: mixer width. Must be ≥ 4+clog2(CHANNELS).
- `phi2` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-`phi2` strobe, the base audio clock (the 64 kHz equivalent).
- `we` in 1: write strobe, sampled on `phi2` when `cs` is high.
- `cs` in 1: chip select.
- `a` in 5: register address.
- `d_in` in 8: write data.
- `aud` out `OUT_W`: unsigned mixed output.
- `chan_out` out `CHANNELS`: per-channel raw output bits, for debug and test.

## Operation
**Register map**
- `AUDF[n]` at 2n, `AUDC[n]` at 2n+1.
- `AUDCTL` at 5'h1E.
- Write-only strobe `RESTART` at 5'h1F.
- Writes to unmapped addresses are ignored. There are no readbacks.

**AUDC[n] fields**
- [7] tone: 1 = square wave, 0 = noise.
- [5] noise source: 1 = poly4, 0 = poly17/9.
- [4] volume-only.
- [3:0] volume. Bit 6 is reserved and ignored.

**AUDCTL fields**
- Bit p (p < CHANNELS/2) links pair (2p, 2p+1).
- Bit 7 = 1 selects poly9 in place of poly17.

**Divider, unlinked channel**
- 8-bit down-counter `cnt[n]`, advanced only on `tick`.
- When `cnt` = 0: reload from `AUDF[n]` and flag underflow. Otherwise decrement.
- Underflow period = AUDF+1 ticks.

**Divider, linked pair p**
- The pair forms one 16-bit counter with reload {AUDF[2p+1], AUDF[2p]}. Period = N+1 ticks.
- Underflow events go to channel 2p+1.
- Channel 2p's output is forced to 0 and it contributes 0 to the mix.

**Channel output bit, updated only on underflow**
- Tone: the bit toggles.
- Noise: the bit takes the selected poly's current MSB.

**Noise sources**
- poly4, poly9 and poly17 are Fibonacci XOR LFSRs, shifted every `phi2`, independent of `tick`.
- Taps: poly4 x^4+x^3+1, poly9 x^9+x^5+1, poly17 x^17+x^14+1.
- poly9 is the low 9 bits of the poly17 register run in 9-bit mode. Switching modes does not reseed it.

**Mixer**
- `aud` = Σ over channels of (volume-only ? volume : (out ? volume : 0)).
- The sum is registered, zero-extended to `OUT_W`, and never saturates under legal parameters.

**RESTART write**
- Every counter reloads from its AUDF (linked pairs from the 16-bit value).
- No underflow is flagged, and output bits are cleared to 0.

**Reset**
- All AUDF, AUDC, AUDCTL, counters, `chan_out` and `aud` go to 0.
- All LFSRs go to all-ones.

## Timing
- A register write on cycle t is visible to the divider/mixer logic on cycle t+1.
- An AUDF write does not reload the counter. The new value is used at the next underflow.
- Write and underflow in the same cycle: the reload uses the pre-write AUDF.
- A RESTART coinciding with `tick`: the reload wins, with no decrement on that cycle.
- Changing a link bit takes effect on the next `tick`. Counters are not reloaded, and the combined counter starts from the current {cnt[2p+1], cnt[2p]}.
- `chan_out` updates on the cycle the underflow is processed. `aud` follows one `phi2` later (latency 1).
- Volume-only writes reach `aud` 2 cycles after the write cycle.
- `reset` has priority over every other input. Asserted mid-note, all outputs read 0 on the following cycle.
- `tick` held high continuously is legal: the dividers run every `phi2`.

## Test plan
- **Reset:** assert `reset` 1 cycle after random writes -> `aud` = 0, `chan_out` = 0. A tone on channel 0 is silent until reprogrammed.
- **Tone:** AUDF0 = 3, AUDC0 = 8'hAF, `tick` every cycle -> `chan_out[0]` toggles every 4 cycles; `aud` alternates 0/15, lagging by 1 cycle.
- **Linked pair:** AUDCTL = 8'h01, AUDF0 = 8'h01, AUDF1 = 8'h01, AUDC1 = 8'hA8 -> channel 1 toggles every 258 ticks; `chan_out[0]` stays 0.
- **Volume-only mix:** all four AUDC = 8'h1F -> `aud` = 60. Then write AUDC2 = 8'h10 -> `aud` = 45 two cycles later.
- **Noise:** AUDC0 = 8'h2F (poly4), AUDF0 = 0, `tick` every cycle -> `chan_out[0]` follows the poly4 MSB sequence, period 15 from reset seed 4'hF.
- **RESTART collision:** write RESTART on a `tick` cycle where cnt0 = 0 -> no toggle, cnt0 = AUDF0, `chan_out` = 0. A write to AUDF0 during underflow leaves the reload at the old value.
